// File: rtl/shift_rx_pkg.sv
// ---------------------------------------------------------------------------
// shift_rx_pkg
// Shared definitions for the serial-to-parallel receiver:
//   state_t        - receiver FSM states (IDLE: no partial frame, SHIFT: partial
//                    frame held)
//   WIDTH_DEFAULT  - default parallel word width
//   cnt_w()        - bit-counter width for a given word width
// No ports (package).
// ---------------------------------------------------------------------------
package shift_rx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WIDTH_DEFAULT = 4;

    // Counter must hold values 0..WIDTH, hence one bit above clog2.
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/shift_rx_core.sv
// ---------------------------------------------------------------------------
// shift_rx_core
// Directional shift register with bit counter. Collects WIDTH serial bits
// into a word, shifting left (MSB first) or right (LSB first) according to
// the direction latched on the first bit of each frame.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset
//   i_clr        in   abort the partial frame (frame sync)
//   i_first      in   the bit offered this cycle starts a new frame
//   i_shift      in   accept i_sdi this cycle
//   i_sdi        in   serial data bit
//   i_msb_first  in   direction for a frame starting this cycle
//   o_done       out  this cycle's accepted bit completes the word
//   o_next_word  out  word contents including this cycle's bit
// ---------------------------------------------------------------------------
module shift_rx_core
    import shift_rx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_first,
    input  logic             i_shift,
    input  logic             i_sdi,
    input  logic             i_msb_first,
    output logic             o_done,
    output logic [WIDTH-1:0] o_next_word
);

    localparam int CW = cnt_w(WIDTH);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_word;
    logic             r_dir;

    logic [CW-1:0]    w_cnt_base;
    logic [WIDTH-1:0] w_word_base;
    logic             w_dir;

    // A frame sync in the same cycle as a valid bit makes that bit the first
    // of a fresh frame, so the cleared state is what gets shifted.
    assign w_cnt_base  = i_clr ? '0 : r_cnt;
    assign w_word_base = i_clr ? '0 : r_word;
    assign w_dir       = i_first ? i_msb_first : r_dir;

    assign o_next_word = w_dir ? {w_word_base[WIDTH-2:0], i_sdi}
                               : {i_sdi, w_word_base[WIDTH-1:1]};
    assign o_done      = i_shift && (w_cnt_base == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_word <= '0;
            r_dir  <= 1'b0;
        end else if (i_shift) begin
            r_dir <= w_dir;
            if (o_done) begin
                r_cnt  <= '0;
                r_word <= '0;
            end else begin
                r_cnt  <= w_cnt_base + 1'b1;
                r_word <= o_next_word;
            end
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_word <= '0;
        end
    end

endmodule

// File: rtl/shift_rx.sv
// ---------------------------------------------------------------------------
// shift_rx
// Serial-to-parallel receiver with a one-deep output buffer and a sticky
// overrun flag. Holds the frame FSM, output buffer and overrun logic; the
// shifting itself lives in shift_rx_core.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   sdi        in   serial data bit
//   s_valid    in   sdi holds a valid bit this cycle
//   msb_first  in   1: first bit is word bit WIDTH-1; 0: first bit is bit 0
//   start      in   frame sync, aborts a partial frame and clears overrun
//   Q          out  received parallel word
//   q_valid    out  Q holds an unconsumed word
//   q_ready    in   consumer accepts Q when q_valid & q_ready
//   overrun    out  sticky: a completed word was dropped
// ---------------------------------------------------------------------------
module shift_rx
    import shift_rx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sdi,
    input  logic             s_valid,
    input  logic             msb_first,
    input  logic             start,
    output logic [WIDTH-1:0] Q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             overrun
);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             r_overrun;

    logic             w_first;
    logic             w_done;
    logic [WIDTH-1:0] w_next_word;

    assign w_first = start || (r_state == IDLE);

    shift_rx_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (start),
        .i_first    (w_first),
        .i_shift    (s_valid),
        .i_sdi      (sdi),
        .i_msb_first(msb_first),
        .o_done     (w_done),
        .o_next_word(w_next_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_valid) r_state <= SHIFT;
                end
                SHIFT: begin
                    if (s_valid) r_state <= w_done ? IDLE : SHIFT;
                    else if (start) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (start) r_overrun <= 1'b0;

            // A completing word replaces the buffer only if the buffer is
            // empty or being drained this same edge; otherwise it is lost.
            if (w_done) begin
                if (!r_q_valid || q_ready) begin
                    r_q       <= w_next_word;
                    r_q_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_q_valid && q_ready) begin
                r_q_valid <= 1'b0;
            end
        end
    end

    assign Q       = r_q;
    assign q_valid = r_q_valid;
    assign overrun = r_overrun;

endmodule

// File: doc/shift_rx.md
SHIFT_RX -- requirements
Module: shift_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port sdi, input, 1 bit: serial data bit.
REQ-005 The block SHALL have port s_valid, input, 1 bit: sdi holds a valid bit this cycle.
REQ-006 The block SHALL have port msb_first, input, 1 bit: 1 means the first bit of the frame is word bit WIDTH-1; 0 means it is bit 0.
REQ-007 The block SHALL have port start, input, 1 bit: frame-sync pulse that aborts any partial frame.
REQ-008 The block SHALL have port Q, output, WIDTH bits: received parallel word.
REQ-009 The block SHALL have port q_valid, output, 1 bit: Q holds an unconsumed word.
REQ-010 The block SHALL have port q_ready, input, 1 bit: the consumer accepts Q when q_valid and q_ready are both 1.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag, set when a completed word is dropped.

Function
REQ-012 The block SHALL use a two-state FSM: IDLE (no partial frame) and SHIFT (1..WIDTH-1 bits held).
REQ-013 The block SHALL accept a bit on every edge where s_valid=1; s_valid=0 SHALL leave all shift state unchanged.
REQ-014 The block SHALL latch msb_first on the first bit of each frame and SHALL ignore changes to it until that frame ends.
REQ-015 When msb_first=1, each accepted bit SHALL shift the word register left with sdi entering bit 0; when msb_first=0, it SHALL shift right with sdi entering bit WIDTH-1.
REQ-016 A bit counter of width ceil(log2(WIDTH))+1 SHALL count accepted bits; IDLE->SHIFT on the first bit; SHIFT->IDLE on bit WIDTH.
REQ-017 The word SHALL be complete on the edge that accepts bit WIDTH; Q and q_valid SHALL update on that same edge (zero added latency; visible in the next cycle).
REQ-018 Q SHALL be a one-deep output buffer, so reception of the next frame continues while q_valid=1.
REQ-019 Handshake: q_valid=1 and q_ready=1 at an edge SHALL clear q_valid, unless a new word completes at that same edge, in which case Q SHALL load the new word and q_valid SHALL stay 1.
REQ-020 If a word completes while q_valid=1 and q_ready=0, Q SHALL keep the old word, the new word SHALL be dropped, and overrun SHALL set to 1.
REQ-021 start=1 SHALL clear the counter and partial word and SHALL clear overrun; if s_valid=1 in the same cycle, that sdi SHALL be bit 1 of the new frame, using the msb_first value of that cycle.
REQ-022 start SHALL NOT alter Q or q_valid.
REQ-023 Q SHALL remain stable while q_valid=1 and no handshake occurs.

Reset
REQ-024 On rst_n=0 at an edge: state SHALL go to IDLE, counter=0, word register=0, Q=0, q_valid=0, overrun=0.
REQ-025 Reset SHALL override start, s_valid and q_ready, and SHALL discard any partial frame mid-operation.

Structure
REQ-026 Package shift_rx_pkg SHALL hold the FSM state enum, the default WIDTH constant, and the counter-width function.
REQ-027 The directional shift register with counter SHALL be sub-module shift_rx_core; the top level SHALL hold the FSM, output buffer and overrun logic.

Verification
REQ-028 WIDTH=4, msb_first=1, sdi 1,0,1,1 on consecutive s_valid cycles, q_ready=0 -> Q=4'b1011, q_valid=1 in the cycle after bit 4.
REQ-029 msb_first=0, sdi 1,0,1,1 -> Q=4'b1101.
REQ-030 q_ready=0, send frame 1011 then frame 0110 -> Q stays 1011, overrun=1; then start pulse -> overrun=0, Q=1011 still valid.
REQ-031 q_ready=1 held, back-to-back frames 1100 and 0011 with s_valid continuous -> q_valid high one cycle each, Q=1100 then 0011, overrun=0.
REQ-032 Send 2 bits 1,1, then start with s_valid=1, sdi=0, followed by 1,0,1 -> Q=4'b0101 (msb_first=1).
REQ-033 Send 3 bits, then assert rst_n=0 for one cycle, then send 4 bits 1,1,1,0 -> Q=4'b1110 with no residue from the partial frame, and Q=0, q_valid=0 during reset.
